// File: rtl/ddr3_pkg.sv
// Shared DDR3 Avalon-side definitions: bus widths, arbiter states and grant encodings.
// Imported by the arbiter and any future DDR3 user-side blocks.
package ddr3_pkg;

  localparam int DDR3_ADDR_W = 26;
  localparam int DDR3_DATA_W = 128;
  localparam int DDR3_SIZE_W = 3;

  typedef enum logic [1:0] {
    ARB_IDLE     = 2'd0,
    ARB_RD_CMD   = 2'd1,
    ARB_WR_BURST = 2'd2
  } arb_state_t;

  // Grant is {wr,rd} one-hot so it can be probed directly on a logic analyser
  localparam logic [1:0] GRANT_IDLE = 2'b00;
  localparam logic [1:0] GRANT_RD   = 2'b01;
  localparam logic [1:0] GRANT_WR   = 2'b10;

endpackage

// File: rtl/ddr3_avl_arbiter.sv
// Registered two-master arbiter for the single DDR3 Avalon-MM port: reads have priority,
// writes own the port for a whole burst, and a starvation limit bounds write latency.
module ddr3_avl_arbiter
  import ddr3_pkg::*;
#(
  parameter int ADDR_W          = DDR3_ADDR_W,
  parameter int DATA_W          = DDR3_DATA_W,
  parameter int SIZE_W          = DDR3_SIZE_W,
  parameter int WR_STARVE_LIMIT = 64
) (
  input  logic              ddr3_clk,
  input  logic              ddr3_reset_n,
  input  logic              rd_req,
  input  logic              rd_burstbegin,
  input  logic [SIZE_W-1:0] rd_size,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ready,
  input  logic              wr_req,
  input  logic              wr_burstbegin,
  input  logic [SIZE_W-1:0] wr_size,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic              avl_ready,
  output logic              avl_read_req,
  output logic              avl_write_req,
  output logic              avl_burstbegin,
  output logic [SIZE_W-1:0] avl_size,
  output logic [ADDR_W-1:0] avl_addr,
  output logic [DATA_W-1:0] avl_wr_data,
  output logic [1:0]        grant,
  output logic [15:0]       starve_events
);

  localparam logic [7:0] STARVE_LIMIT = 8'(WR_STARVE_LIMIT);

  arb_state_t        r_state;
  arb_state_t        w_next_state;
  logic [SIZE_W-1:0] r_beat_cnt;
  logic [7:0]        r_starve_cnt;
  logic [15:0]       r_starve_events;

  logic w_starve_hit;
  logic w_wr_grant;
  logic w_wr_accept;

  assign w_starve_hit = wr_req && (r_starve_cnt >= STARVE_LIMIT);
  assign w_wr_grant   = (r_state == ARB_IDLE) && (w_next_state == ARB_WR_BURST);
  assign w_wr_accept  = (r_state == ARB_WR_BURST) && wr_req && avl_ready;

  always_ff @(posedge ddr3_clk or negedge ddr3_reset_n) begin
    if (!ddr3_reset_n) begin
      r_state <= ARB_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Every completed command returns through IDLE, giving a one-cycle re-arbitration bubble
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ARB_IDLE: begin
        if (w_starve_hit) begin
          w_next_state = ARB_WR_BURST;
        end else if (rd_req) begin
          w_next_state = ARB_RD_CMD;
        end else if (wr_req) begin
          w_next_state = ARB_WR_BURST;
        end
      end
      ARB_RD_CMD: begin
        if (!rd_req || avl_ready) begin
          w_next_state = ARB_IDLE;
        end
      end
      ARB_WR_BURST: begin
        if (w_wr_accept && (r_beat_cnt == SIZE_W'(1))) begin
          w_next_state = ARB_IDLE;
        end
      end
      default: w_next_state = ARB_IDLE;
    endcase
  end

  // A zero-length burst is treated as a single beat so the grant can never hang
  always_ff @(posedge ddr3_clk or negedge ddr3_reset_n) begin
    if (!ddr3_reset_n) begin
      r_beat_cnt <= '0;
    end else if (w_wr_grant) begin
      r_beat_cnt <= (wr_size == '0) ? SIZE_W'(1) : wr_size;
    end else if (w_wr_accept && (r_beat_cnt != '0)) begin
      r_beat_cnt <= r_beat_cnt - SIZE_W'(1);
    end
  end

  always_ff @(posedge ddr3_clk or negedge ddr3_reset_n) begin
    if (!ddr3_reset_n) begin
      r_starve_cnt <= '0;
    end else if (w_wr_grant) begin
      r_starve_cnt <= '0;
    end else if (wr_req && (r_state != ARB_WR_BURST) && (r_starve_cnt != 8'hFF)) begin
      r_starve_cnt <= r_starve_cnt + 8'd1;
    end
  end

  always_ff @(posedge ddr3_clk or negedge ddr3_reset_n) begin
    if (!ddr3_reset_n) begin
      r_starve_events <= '0;
    end else if ((r_state == ARB_IDLE) && w_starve_hit && (r_starve_events != 16'hFFFF)) begin
      r_starve_events <= r_starve_events + 16'd1;
    end
  end

  assign starve_events = r_starve_events;

  always_comb begin
    avl_read_req   = 1'b0;
    avl_write_req  = 1'b0;
    avl_burstbegin = 1'b0;
    avl_size       = '0;
    avl_addr       = '0;
    avl_wr_data    = '0;
    rd_ready       = 1'b0;
    wr_ready       = 1'b0;
    grant          = GRANT_IDLE;
    case (r_state)
      ARB_RD_CMD: begin
        avl_read_req   = rd_req;
        avl_burstbegin = rd_burstbegin;
        avl_size       = rd_size;
        avl_addr       = rd_addr;
        rd_ready       = avl_ready;
        grant          = GRANT_RD;
      end
      ARB_WR_BURST: begin
        avl_write_req  = wr_req;
        avl_burstbegin = wr_burstbegin;
        avl_size       = wr_size;
        avl_addr       = wr_addr;
        avl_wr_data    = wr_data;
        wr_ready       = avl_ready;
        grant          = GRANT_WR;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ddr3_avl_arbiter.sv
// Directed bench for ddr3_avl_arbiter: a per-cycle vector table plus hand-written
// starvation and reset-mid-burst sequences. Inputs change on the falling edge.
module tb_ddr3_avl_arbiter;
  import ddr3_pkg::*;

  logic         clk = 1'b0;
  logic         resetN;
  logic         rdReq, rdBb, wrReq, wrBb, avlReady;
  logic [2:0]   rdSize, wrSize;
  logic [25:0]  rdAddr, wrAddr;
  logic [127:0] wrData;
  logic         rdReady, wrReady, avlReadReq, avlWriteReq, avlBb;
  logic [2:0]   avlSize;
  logic [25:0]  avlAddr;
  logic [127:0] avlWrData;
  logic [1:0]   grant;
  logic [15:0]  starveEvents;

  int errors = 0;
  int checks = 0;

  localparam logic [127:0] D0 = {4{32'hD0D0_0001}};
  localparam logic [127:0] D1 = {4{32'hD1D1_0002}};
  localparam logic [127:0] D2 = {4{32'hD2D2_0003}};
  localparam logic [127:0] D3 = {4{32'hD3D3_0004}};
  localparam logic [127:0] E0 = {4{32'hE0E0_0005}};
  localparam logic [127:0] E1 = {4{32'hE1E1_0006}};
  localparam logic [127:0] F0 = {4{32'hF0F0_0007}};

  typedef struct {
    string        name;
    logic [30:0]  rdIn;
    logic [30:0]  wrIn;
    logic [127:0] data;
    logic         ready;
    logic [35:0]  expCtrl;
    logic [127:0] expData;
  } vec_t;

  vec_t vecs[$];

  ddr3_avl_arbiter #(.WR_STARVE_LIMIT(4)) dut (
    .ddr3_clk(clk), .ddr3_reset_n(resetN),
    .rd_req(rdReq), .rd_burstbegin(rdBb), .rd_size(rdSize), .rd_addr(rdAddr), .rd_ready(rdReady),
    .wr_req(wrReq), .wr_burstbegin(wrBb), .wr_size(wrSize), .wr_addr(wrAddr), .wr_data(wrData),
    .wr_ready(wrReady), .avl_ready(avlReady), .avl_read_req(avlReadReq), .avl_write_req(avlWriteReq),
    .avl_burstbegin(avlBb), .avl_size(avlSize), .avl_addr(avlAddr), .avl_wr_data(avlWrData),
    .grant(grant), .starve_events(starveEvents)
  );

  always #5 clk = ~clk;

  function automatic logic [30:0] rdv(logic q, logic b, logic [2:0] s, logic [25:0] a);
    return {q, b, s, a};
  endfunction

  function automatic logic [30:0] wrv(logic q, logic b, logic [2:0] s, logic [25:0] a);
    return {q, b, s, a};
  endfunction

  function automatic logic [35:0] ctl(logic rq, logic wq, logic b, logic [2:0] s, logic [25:0] a,
                                      logic rr, logic wr, logic [1:0] g);
    return {rq, wq, b, s, a, rr, wr, g};
  endfunction

  function automatic vec_t mkVec(string n, logic [30:0] r, logic [30:0] w, logic [127:0] d,
                                 logic rdy, logic [35:0] ec, logic [127:0] ed);
    vec_t v;
    v.name = n; v.rdIn = r; v.wrIn = w; v.data = d; v.ready = rdy; v.expCtrl = ec; v.expData = ed;
    return v;
  endfunction

  function automatic logic [35:0] actualCtrl();
    return {avlReadReq, avlWriteReq, avlBb, avlSize, avlAddr, rdReady, wrReady, grant};
  endfunction

  task automatic checkOutput(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One cycle: drive on the falling edge, compare just after, state advances on the next rising edge
  task automatic applyStimulus(vec_t v);
    @(negedge clk);
    {rdReq, rdBb, rdSize, rdAddr} = v.rdIn;
    {wrReq, wrBb, wrSize, wrAddr} = v.wrIn;
    wrData   = v.data;
    avlReady = v.ready;
    #1;
    checkOutput({v.name, "_ctl"}, 128'(actualCtrl()), 128'(v.expCtrl));
    checkOutput({v.name, "_data"}, avlWrData, v.expData);
  endtask

  task automatic addVec(string n, logic [30:0] r, logic [30:0] w, logic [127:0] d,
                        logic rdy, logic [35:0] ec, logic [127:0] ed);
    vecs.push_back(mkVec(n, r, w, d, rdy, ec, ed));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [35:0] z;
    logic [30:0] r0;
    int found;
    int reads;
    z  = '0;
    r0 = '0;

    addVec("rd_a_idle",   rdv(1,1,4,'h123), r0, '0, 1, z, '0);
    addVec("rd_a_cmd",    rdv(1,1,4,'h123), r0, '0, 1, ctl(1,0,1,4,'h123,1,0,GRANT_RD), '0);
    addVec("rd_a_done",   r0, r0, '0, 1, z, '0);
    addVec("wr_b_idle",   r0, wrv(1,1,4,'h200), D0, 1, z, '0);
    addVec("wr_b_beat0",  r0, wrv(1,1,4,'h200), D0, 1, ctl(0,1,1,4,'h200,0,1,GRANT_WR), D0);
    addVec("wr_b_stall1", rdv(1,1,2,'h321), wrv(1,0,4,'h200), D1, 0, ctl(0,1,0,4,'h200,0,0,GRANT_WR), D1);
    addVec("wr_b_beat1",  rdv(1,1,2,'h321), wrv(1,0,4,'h200), D1, 1, ctl(0,1,0,4,'h200,0,1,GRANT_WR), D1);
    addVec("wr_b_stall2", rdv(1,1,2,'h321), wrv(1,0,4,'h200), D2, 0, ctl(0,1,0,4,'h200,0,0,GRANT_WR), D2);
    addVec("wr_b_beat2",  rdv(1,1,2,'h321), wrv(1,0,4,'h200), D2, 1, ctl(0,1,0,4,'h200,0,1,GRANT_WR), D2);
    addVec("wr_b_stall3", rdv(1,1,2,'h321), wrv(1,0,4,'h200), D3, 0, ctl(0,1,0,4,'h200,0,0,GRANT_WR), D3);
    addVec("wr_b_beat3",  rdv(1,1,2,'h321), wrv(1,0,4,'h200), D3, 1, ctl(0,1,0,4,'h200,0,1,GRANT_WR), D3);
    addVec("wr_b_bubble", rdv(1,1,2,'h321), r0, '0, 1, z, '0);
    addVec("wr_b_rd",     rdv(1,1,2,'h321), r0, '0, 1, ctl(1,0,1,2,'h321,1,0,GRANT_RD), '0);
    addVec("wr_b_rddone", r0, r0, '0, 1, z, '0);
    addVec("ct_idle",     rdv(1,1,1,'h40), wrv(1,1,2,'h80), E0, 1, z, '0);
    addVec("ct_rd",       rdv(1,1,1,'h40), wrv(1,1,2,'h80), E0, 1, ctl(1,0,1,1,'h40,1,0,GRANT_RD), '0);
    addVec("ct_bubble",   r0, wrv(1,1,2,'h80), E0, 1, z, '0);
    addVec("ct_wr0",      r0, wrv(1,1,2,'h80), E0, 1, ctl(0,1,1,2,'h80,0,1,GRANT_WR), E0);
    addVec("ct_wr1",      r0, wrv(1,0,2,'h80), E1, 1, ctl(0,1,0,2,'h80,0,1,GRANT_WR), E1);
    addVec("ct_done",     r0, r0, '0, 1, z, '0);
    addVec("sz_idle",     r0, wrv(1,1,0,'h55), F0, 1, z, '0);
    addVec("sz_wr",       r0, wrv(1,1,0,'h55), F0, 1, ctl(0,1,1,0,'h55,0,1,GRANT_WR), F0);
    addVec("sz_done",     r0, r0, '0, 1, z, '0);
    addVec("rs_idle",     rdv(1,1,3,'h77), r0, '0, 0, z, '0);
    addVec("rs_stall",    rdv(1,1,3,'h77), r0, '0, 0, ctl(1,0,1,3,'h77,0,0,GRANT_RD), '0);
    addVec("rs_drop",     rdv(0,0,3,'h77), r0, '0, 0, ctl(0,0,0,3,'h77,0,0,GRANT_RD), '0);
    addVec("rs_idle2",    r0, r0, '0, 0, z, '0);

    resetN = 1'b0;
    rdReq = 1'b1; rdBb = 1'b1; rdSize = 3'd2; rdAddr = 26'h11;
    wrReq = 1'b1; wrBb = 1'b1; wrSize = 3'd2; wrAddr = 26'h22; wrData = D0; avlReady = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_ctl", 128'(actualCtrl()), '0);
    checkOutput("reset_data", avlWrData, '0);
    checkOutput("reset_events", 128'(starveEvents), '0);
    @(negedge clk);
    {rdReq, rdBb, rdSize, rdAddr} = r0;
    {wrReq, wrBb, wrSize, wrAddr} = r0;
    wrData = '0;
    resetN = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
    end

    // Reads held continuously: the write must be forced in after two read turnarounds
    found = -1;
    reads = 0;
    for (int step = 0; step < 20; step++) begin
      @(negedge clk);
      {rdReq, rdBb, rdSize, rdAddr} = rdv(1,1,4,'h1A0);
      {wrReq, wrBb, wrSize, wrAddr} = wrv(1,1,1,'h2B0);
      wrData = D2;
      avlReady = 1'b1;
      #1;
      if (grant == GRANT_RD) reads++;
      if (grant == GRANT_WR) begin
        found = step;
        break;
      end
    end
    checkOutput("starve_grant_step", 128'(found), 128'(5));
    checkOutput("starve_reads", 128'(reads), 128'(2));
    checkOutput("starve_events_one", 128'(starveEvents), 128'(1));
    checkOutput("starve_cnt_clear", 128'(dut.r_starve_cnt), '0);
    checkOutput("starve_wr_data", avlWrData, D2);
    @(negedge clk);
    rdReq = 1'b0; wrReq = 1'b0;
    #1;
    checkOutput("starve_after_grant", 128'(grant), 128'(GRANT_IDLE));
    checkOutput("starve_events_hold", 128'(starveEvents), 128'(1));

    applyStimulus(mkVec("rb_idle",  r0, wrv(1,1,4,'h300), D0, 1, z, '0));
    applyStimulus(mkVec("rb_beat0", r0, wrv(1,1,4,'h300), D0, 1, ctl(0,1,1,4,'h300,0,1,GRANT_WR), D0));
    applyStimulus(mkVec("rb_beat1", r0, wrv(1,0,4,'h300), D1, 1, ctl(0,1,0,4,'h300,0,1,GRANT_WR), D1));
    #2;
    resetN = 1'b0;
    #1;
    checkOutput("rb_async_ctl", 128'(actualCtrl()), '0);
    checkOutput("rb_async_data", avlWrData, '0);
    checkOutput("rb_async_events", 128'(starveEvents), '0);
    checkOutput("rb_beat_cnt", 128'(dut.r_beat_cnt), '0);
    @(negedge clk);
    {rdReq, rdBb, rdSize, rdAddr} = r0;
    {wrReq, wrBb, wrSize, wrAddr} = r0;
    wrData = '0;
    resetN = 1'b1;
    applyStimulus(mkVec("ar_idle", rdv(1,1,5,'h3AB), r0, '0, 1, z, '0));
    applyStimulus(mkVec("ar_cmd",  rdv(1,1,5,'h3AB), r0, '0, 1, ctl(1,0,1,5,'h3AB,1,0,GRANT_RD), '0));
    applyStimulus(mkVec("ar_done", r0, r0, '0, 1, z, '0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ddr3_avl_arbiter.md
Name: ddr3_avl_arbiter

Overview:
- Sequences the single DDR3 Avalon-MM port between two masters:
  - the display read engine (read master), which issues one command per read burst;
  - the CSR/test write engine (write master), which issues multi-beat write bursts.
- Replaces ad-hoc combinational muxing of address/size/burstbegin with a registered grant that is held for a whole write burst.
- Read priority protects the VGA data FIFO; a starvation limit bounds write latency.
- Sits between the read/write engines and the DDR3 controller, entirely in the ddr3_clk domain.

Parameters:
- ADDR_W, 26, Avalon word address width
- DATA_W, 128, Avalon data width
- SIZE_W, 3, burst size field width
- WR_STARVE_LIMIT, 64, cycles a pending write may wait before it is forced ahead of reads (1..255)

Ports:
- ddr3_clk  in  1  DDR3 controller user clock
- ddr3_reset_n  in  1  reset, asynchronous, active-low
- rd_req  in  1  read master command request
- rd_burstbegin  in  1  read master burstbegin
- rd_size  in  SIZE_W  read burst length in beats
- rd_addr  in  ADDR_W  read address
- rd_ready  out  1  read command accepted this cycle
- wr_req  in  1  write master beat request
- wr_burstbegin  in  1  write master burstbegin (first beat)
- wr_size  in  SIZE_W  write burst length in beats
- wr_addr  in  ADDR_W  write burst address
- wr_data  in  DATA_W  write beat data
- wr_ready  out  1  write beat accepted this cycle
- avl_ready  in  1  controller ready
- avl_read_req  out  1  to controller
- avl_write_req  out  1  to controller
- avl_burstbegin  out  1  to controller
- avl_size  out  SIZE_W  to controller
- avl_addr  out  ADDR_W  to controller
- avl_wr_data  out  DATA_W  to controller
- grant  out  2  {wr,rd} one-hot current owner, 00 when idle (debug)
- starve_events  out  16  saturating count of forced-write grants

Behaviour:
- Reset (async, ddr3_reset_n low):
  - state IDLE, beat counter 0, starve counter 0, starve_events 0.
  - All outputs 0.
  - Reset mid-burst abandons the burst; masters are also reset from ddr3_reset_n.
- States: IDLE, RD_CMD, WR_BURST. Owner is registered, so there is 1 cycle of arbitration latency from a request in IDLE to visibility on the avl_* outputs.
- IDLE:
  - All avl_* outputs 0; rd_ready = wr_ready = 0.
  - Next state, in priority order:
    1. wr_req && starve_cnt >= WR_STARVE_LIMIT -> WR_BURST, starve_events++.
    2. rd_req -> RD_CMD.
    3. wr_req -> WR_BURST.
    4. Otherwise stay in IDLE.
  - On entering WR_BURST: load beat_cnt = (wr_size==0 ? 1 : wr_size).
- RD_CMD:
  - avl_read_req = rd_req.
  - avl_burstbegin = rd_burstbegin, avl_size = rd_size, avl_addr = rd_addr.
  - avl_write_req = 0; avl_wr_data = 0.
  - rd_ready = avl_ready.
  - rd_req && avl_ready -> IDLE.
  - rd_req deasserted (protocol violation) -> IDLE with no command issued.
- WR_BURST:
  - avl_write_req = wr_req.
  - avl_burstbegin = wr_burstbegin, avl_size = wr_size, avl_addr = wr_addr, avl_wr_data = wr_data.
  - wr_ready = avl_ready.
  - Beat accepted when wr_req && avl_ready: beat_cnt--.
  - Acceptance with beat_cnt==1 -> IDLE.
  - Read requests are ignored until the burst completes; no preemption mid-burst.
- Back-to-back: after a command completes, the arbiter always spends one cycle in IDLE (re-arbitration bubble).
- Starve counter (8 bit, saturating at 255):
  - increments each cycle wr_req=1 and state != WR_BURST;
  - clears on entry to WR_BURST;
  - holds when wr_req=0.
- avl_read_req and avl_write_req are never both 1. grant = 01 in RD_CMD, 10 in WR_BURST.
- Simultaneous events:
  - Last write beat accepted with rd_req pending: go to IDLE, then RD_CMD on the next cycle.
  - Read accepted with wr_req pending: go to IDLE; write wins next only if it has reached the limit or rd_req=0.
- starve_events saturates at 0xFFFF.

Decomposition:
- Package ddr3_pkg:
  - DDR3_ADDR_W=26, DDR3_DATA_W=128, DDR3_SIZE_W=3.
  - Arbiter state enum {IDLE, RD_CMD, WR_BURST}.
  - Grant encoding constants.
- No sub-module. The starve counter and beat counter are local always blocks; the output mux is a single combinational block keyed on state.

Test Plan:
- Single read: rd_req=1, addr=0x123, size=4, avl_ready=1 -> avl_read_req high exactly 1 cycle at T+1 with addr 0x123, size 4; rd_ready pulses once; returns to IDLE.
- Write burst with stalls: wr_size=4, avl_ready toggling 1,0,1,0,... -> exactly 4 accepted beats, data D0..D3 in order; avl_write_req drops and grant=00 after 4th acceptance; rd_req raised mid-burst is not granted until after.
- Contention: rd_req and wr_req both asserted from idle, starve_cnt=0 -> RD_CMD granted first, WR_BURST on the following arbitration.
- Starvation: WR_STARVE_LIMIT=4, rd_req held continuously, wr_req held -> write granted once starve_cnt>=4 (within 4 read turnarounds); starve_events=1; starve_cnt=0 after grant.
- Size zero: wr_size=0 -> treated as 1 beat; IDLE after one acceptance.
- Reset mid-burst: assert ddr3_reset_n low during beat 2 of 4 -> all outputs 0 immediately (async), grant=00, counters 0; after release a new rd_req is serviced normally.
